// File: rtl/arp_rx_multi.sv
// ARP receiver on a GMII byte stream: preamble, Ethernet/802.1Q header, ARP body,
// target-IP lookup across IP_NUM local addresses, saturating malformed-frame counter.
// Ports:
//   clk, rst_n (async, active-low)
//   gmii_rx_dv, gmii_rxd[7:0] : receive stream
//   local_ip[32*IP_NUM-1:0]   : local IP table, entry i at [32*i+31:32*i]
//   arp_rx_done               : one-cycle pulse per accepted packet
//   arp_rx_type               : 0 request, 1 reply
//   src_mac, src_ip           : sender addresses of last accepted packet
//   ip_idx                    : lowest matching local_ip index
//   err_cnt                   : saturating malformed-frame count
module arp_rx_multi #(
   parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
   parameter int          IP_NUM    = 4,
   parameter bit          VLAN_EN   = 1'b1,
   parameter int          IDX_W     = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   gmii_rx_dv,
   input  logic [7:0]             gmii_rxd,
   input  logic [32*IP_NUM-1:0]   local_ip,
   output logic                   arp_rx_done,
   output logic                   arp_rx_type,
   output logic [47:0]            src_mac,
   output logic [31:0]            src_ip,
   output logic [IDX_W-1:0]       ip_idx,
   output logic [15:0]            err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_ETH, S_VLAN, S_ARP, S_WAIT
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [4:0]       r_cnt;
   logic             r_armed;
   logic             r_dst_bc;
   logic             r_dst_me;
   logic [7:0]       r_type_hi;
   logic             r_oper;
   logic [47:0]      r_smac;
   logic [31:0]      r_sip;
   logic [23:0]      r_tip;
   logic [15:0]      r_err_cnt;
   logic             w_err;
   logic             w_done;
   logic             w_fmt_bad;
   logic             w_bc_nx;
   logic             w_me_nx;
   logic [7:0]       w_mac_byte;
   logic [15:0]      w_type;
   logic [31:0]      w_tip;
   logic             w_hit;
   logic [IDX_W-1:0] w_hit_idx;

   assign err_cnt = r_err_cnt;
   assign w_type  = {r_type_hi, gmii_rxd};
   assign w_tip   = {r_tip, gmii_rxd};

   // BOARD_MAC byte expected at ETH byte r_cnt (MSB first)
   assign w_mac_byte = 8'(BOARD_MAC >> (6'd40 - {r_cnt[2:0], 3'b000}));

   // destination match flags including the byte on the bus
   assign w_bc_nx = ((r_cnt == 5'd0) | r_dst_bc) & (gmii_rxd == 8'hFF);
   assign w_me_nx = ((r_cnt == 5'd0) | r_dst_me) & (gmii_rxd == w_mac_byte);

   // descending scan so the lowest matching index is left standing
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = IP_NUM - 1; i >= 0; i--) begin
         if (local_ip[32*i +: 32] == w_tip) begin
            w_hit     = 1'b1;
            w_hit_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      w_fmt_bad = 1'b0;
      unique case (r_cnt)
         5'd0, 5'd3, 5'd6: w_fmt_bad = (gmii_rxd != 8'h00);
         5'd1:    w_fmt_bad = (gmii_rxd != 8'h01);
         5'd2:    w_fmt_bad = (gmii_rxd != 8'h08);
         5'd4:    w_fmt_bad = (gmii_rxd != 8'h06);
         5'd5:    w_fmt_bad = (gmii_rxd != 8'h04);
         5'd7:    w_fmt_bad = (gmii_rxd != 8'h01) && (gmii_rxd != 8'h02);
         default: w_fmt_bad = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nx = r_state;
      w_err      = 1'b0;
      w_done     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            // r_armed keeps a mid-frame 0x55 after reset from starting a frame
            if (gmii_rx_dv && r_armed && gmii_rxd == 8'h55)
               w_state_nx = S_PRE;
         end
         S_PRE: begin
            if (!gmii_rx_dv) begin
               w_state_nx = S_IDLE;
               w_err      = 1'b1;
            end else if (r_cnt < 5'd6) begin
               if (gmii_rxd != 8'h55) begin
                  w_state_nx = S_WAIT;
                  w_err      = 1'b1;
               end
            end else if (gmii_rxd == 8'hD5) begin
               w_state_nx = S_ETH;
            end else begin
               w_state_nx = S_WAIT;
               w_err      = 1'b1;
            end
         end
         S_ETH: begin
            if (!gmii_rx_dv) begin
               w_state_nx = S_IDLE;
               w_err      = 1'b1;
            end else if (r_cnt == 5'd5 && !w_bc_nx && !w_me_nx) begin
               w_state_nx = S_WAIT;
            end else if (r_cnt == 5'd13) begin
               if (w_type == 16'h0806)
                  w_state_nx = S_ARP;
               else if (VLAN_EN && w_type == 16'h8100)
                  w_state_nx = S_VLAN;
               else
                  w_state_nx = S_WAIT;
            end
         end
         S_VLAN: begin
            if (!gmii_rx_dv) begin
               w_state_nx = S_IDLE;
               w_err      = 1'b1;
            end else if (r_cnt == 5'd3) begin
               w_state_nx = (w_type == 16'h0806) ? S_ARP : S_WAIT;
            end
         end
         S_ARP: begin
            if (!gmii_rx_dv) begin
               w_state_nx = S_IDLE;
               w_err      = 1'b1;
            end else if (w_fmt_bad) begin
               w_state_nx = S_WAIT;
               w_err      = 1'b1;
            end else if (r_cnt == 5'd27) begin
               w_state_nx = S_WAIT;
               w_done     = w_hit;
            end
         end
         S_WAIT: begin
            if (!gmii_rx_dv)
               w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_armed <= r_armed | ~gmii_rx_dv;
         if (w_state_nx != r_state)
            r_cnt <= '0;
         else if (gmii_rx_dv && r_cnt != 5'd31)
            r_cnt <= r_cnt + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dst_bc  <= 1'b0;
         r_dst_me  <= 1'b0;
         r_type_hi <= '0;
         r_oper    <= 1'b0;
         r_smac    <= '0;
         r_sip     <= '0;
         r_tip     <= '0;
      end else if (gmii_rx_dv) begin
         r_type_hi <= gmii_rxd;
         if (r_state == S_ETH) begin
            r_dst_bc <= w_bc_nx;
            r_dst_me <= w_me_nx;
         end
         if (r_state == S_ARP) begin
            if (r_cnt == 5'd7)
               r_oper <= (gmii_rxd == 8'h02);
            if (r_cnt >= 5'd8 && r_cnt <= 5'd13)
               r_smac <= {r_smac[39:0], gmii_rxd};
            if (r_cnt >= 5'd14 && r_cnt <= 5'd17)
               r_sip <= {r_sip[23:0], gmii_rxd};
            if (r_cnt >= 5'd24 && r_cnt <= 5'd26)
               r_tip <= {r_tip[15:0], gmii_rxd};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arp_rx_done <= 1'b0;
         arp_rx_type <= 1'b0;
         src_mac     <= '0;
         src_ip      <= '0;
         ip_idx      <= '0;
         r_err_cnt   <= '0;
      end else begin
         arp_rx_done <= w_done;
         if (w_done) begin
            arp_rx_type <= r_oper;
            src_mac     <= r_smac;
            src_ip      <= r_sip;
            ip_idx      <= w_hit_idx;
         end
         if (w_err && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_arp_rx_multi.sv
// Bench for arp_rx_multi: directed and random frames into a VLAN-enabled and a
// VLAN-disabled instance, checked against a frame-level reference model.
module tb_arp_rx_multi;

   localparam logic [47:0] BMAC = 48'h00_11_22_33_44_55;
   localparam logic [47:0] BCST = 48'hFFFF_FFFF_FFFF;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic        done;
      logic        typ;
      logic [47:0] mac;
      logic [31:0] ip;
      logic [2:0]  idx;
      logic        err;
   } res_t;
   typedef struct packed {
      logic        typ;
      logic [47:0] mac;
      logic [31:0] ip;
      logic [2:0]  idx;
      logic [15:0] err;
   } st_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         dv = 1'b0;
   logic [7:0]   rxd = 8'h00;
   logic [127:0] lip = {32'hC0A8010B, 32'hC0A8010C, 32'hC0A8010B, 32'hC0A8010A};

   logic         done0, typ0, done1, typ1;
   logic [47:0]  mac0, mac1;
   logic [31:0]  ip0, ip1;
   logic [2:0]   idx0, idx1;
   logic [15:0]  err0, err1;

   int   n_chk = 0;
   int   n_pass = 0;
   int   n_done0 = 0;
   int   n_done1 = 0;
   int   e_done0 = 0;
   int   e_done1 = 0;
   st_t  m0 = '0;
   st_t  m1 = '0;

   arp_rx_multi #(.BOARD_MAC(BMAC), .IP_NUM(4), .VLAN_EN(1'b1), .IDX_W(3)) dut0 (
      .clk(clk), .rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rxd(rxd), .local_ip(lip),
      .arp_rx_done(done0), .arp_rx_type(typ0), .src_mac(mac0), .src_ip(ip0),
      .ip_idx(idx0), .err_cnt(err0));

   arp_rx_multi #(.BOARD_MAC(BMAC), .IP_NUM(4), .VLAN_EN(1'b0), .IDX_W(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rxd(rxd), .local_ip(lip),
      .arp_rx_done(done1), .arp_rx_type(typ1), .src_mac(mac1), .src_ip(ip1),
      .ip_idx(idx1), .err_cnt(err1));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done0) n_done0++;
      if (done1) n_done1++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bq_t mk(input logic [47:0] dst, input bit vl,
                              input logic [15:0] et, input logic [15:0] op,
                              input logic [47:0] sm, input logic [31:0] si,
                              input logic [31:0] ti, input int pad);
      bq_t q;
      for (int i = 0; i < 7; i++) q.push_back(8'h55);
      q.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) q.push_back(dst[8*i +: 8]);
      for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
      if (vl) begin
         q.push_back(8'h81); q.push_back(8'h00);
         q.push_back(8'h00); q.push_back(8'h05);
      end
      q.push_back(et[15:8]); q.push_back(et[7:0]);
      q.push_back(8'h00); q.push_back(8'h01);
      q.push_back(8'h08); q.push_back(8'h00);
      q.push_back(8'h06); q.push_back(8'h04);
      q.push_back(op[15:8]); q.push_back(op[7:0]);
      for (int i = 5; i >= 0; i--) q.push_back(sm[8*i +: 8]);
      for (int i = 3; i >= 0; i--) q.push_back(si[8*i +: 8]);
      for (int i = 0; i < 6; i++) q.push_back(8'h00);
      for (int i = 3; i >= 0; i--) q.push_back(ti[8*i +: 8]);
      for (int i = 0; i < pad + 4; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   // Frame-level outcome: what the receiver should conclude from the whole byte list
   function automatic res_t model(input bq_t f, input bit ven);
      res_t        r;
      int          n;
      int          p;
      logic [15:0] t;
      logic [47:0] dst;
      logic [31:0] tip;
      r = '0;
      n = f.size();
      if (n < 8) begin r.err = 1'b1; return r; end
      for (int i = 0; i < 7; i++)
         if (f[i] != 8'h55) begin r.err = 1'b1; return r; end
      if (f[7] != 8'hD5) begin r.err = 1'b1; return r; end
      if (n < 14) begin r.err = 1'b1; return r; end
      dst = {f[8], f[9], f[10], f[11], f[12], f[13]};
      if (dst != BMAC && dst != BCST) return r;
      if (n < 22) begin r.err = 1'b1; return r; end
      t = {f[20], f[21]};
      p = 22;
      if (ven && t == 16'h8100) begin
         if (n < 26) begin r.err = 1'b1; return r; end
         t = {f[24], f[25]};
         p = 26;
      end
      if (t != 16'h0806) return r;
      if (n < p + 28) begin r.err = 1'b1; return r; end
      if ({f[p], f[p+1]} != 16'h0001 || {f[p+2], f[p+3]} != 16'h0800 ||
          f[p+4] != 8'd6 || f[p+5] != 8'd4 ||
          !({f[p+6], f[p+7]} inside {16'd1, 16'd2})) begin
         r.err = 1'b1;
         return r;
      end
      tip = {f[p+24], f[p+25], f[p+26], f[p+27]};
      for (int i = 0; i < 4; i++) begin
         if (!r.done && lip[32*i +: 32] == tip) begin
            r.done = 1'b1;
            r.idx  = 3'(i);
         end
      end
      r.typ = (f[p+7] == 8'd2);
      r.mac = {f[p+8], f[p+9], f[p+10], f[p+11], f[p+12], f[p+13]};
      r.ip  = {f[p+14], f[p+15], f[p+16], f[p+17]};
      return r;
   endfunction

   function automatic st_t upd(input st_t s, input res_t r);
      st_t o;
      o = s;
      if (r.done) begin
         o.typ = r.typ; o.mac = r.mac; o.ip = r.ip; o.idx = r.idx;
      end
      if (r.err && o.err != 16'hFFFF) o.err = o.err + 16'd1;
      return o;
   endfunction

   task automatic expect_frame(input bq_t f);
      res_t r0;
      res_t r1;
      r0 = model(f, 1'b1);
      r1 = model(f, 1'b0);
      e_done0 += int'(r0.done);
      e_done1 += int'(r1.done);
      m0 = upd(m0, r0);
      m1 = upd(m1, r1);
   endtask

   task automatic drive(input bq_t f);
      foreach (f[i]) begin
         @(posedge clk); #1;
         dv = 1'b1;
         rxd = f[i];
      end
   endtask

   task automatic send(input bq_t f);
      drive(f);
      @(posedge clk); #1;
      dv = 1'b0;
      rxd = 8'($urandom);
   endtask

   task automatic settle();
      @(posedge clk);
      @(negedge clk); #1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, " done0"}, 64'(n_done0), 64'(e_done0));
      chk({tag, " err0"},  64'(err0), 64'(m0.err));
      chk({tag, " type0"}, 64'(typ0), 64'(m0.typ));
      chk({tag, " mac0"},  64'(mac0), 64'(m0.mac));
      chk({tag, " ip0"},   64'(ip0),  64'(m0.ip));
      chk({tag, " idx0"},  64'(idx0), 64'(m0.idx));
      chk({tag, " done1"}, 64'(n_done1), 64'(e_done1));
      chk({tag, " err1"},  64'(err1), 64'(m1.err));
      chk({tag, " mac1"},  64'(mac1), 64'(m1.mac));
   endtask

   task automatic run(input bq_t f, input string tag);
      expect_frame(f);
      send(f);
      settle();
      check_all(tag);
   endtask

   task automatic run2(input bq_t a, input bq_t b, input string tag);
      expect_frame(a);
      expect_frame(b);
      send(a);
      send(b);
      settle();
      check_all(tag);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " done"}, 64'(done0), 64'd0);
      chk({tag, " type"}, 64'(typ0), 64'd0);
      chk({tag, " mac"},  64'(mac0), 64'd0);
      chk({tag, " ip"},   64'(ip0), 64'd0);
      chk({tag, " idx"},  64'(idx0), 64'd0);
      chk({tag, " err"},  64'(err0), 64'd0);
   endtask

   initial begin
      bq_t f;
      bq_t g;
      int  d0;

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      f = mk(BCST, 1'b0, 16'h0806, 16'd1, 48'h00AABBCCDDEE, 32'hC0A80114, 32'hC0A8010C, 18);
      run(f, "bcast_req");
      chk("bcast idx", 64'(idx0), 64'd2);
      chk("bcast mac", 64'(mac0), 64'h00AABBCCDDEE);
      chk("bcast ip",  64'(ip0),  64'hC0A80114);

      f = mk(BMAC, 1'b1, 16'h0806, 16'd2, 48'h0A0B0C0D0E0F, 32'h0A000001, 32'hC0A8010A, 10);
      run(f, "vlan_reply");
      chk("vlan type", 64'(typ0), 64'd1);

      f = mk(BCST, 1'b0, 16'h0806, 16'd1, 48'h112233445566, 32'h0A000002, 32'hC0A8010B, 0);
      run(f, "dup_ip");
      chk("dup idx", 64'(idx0), 64'd1);

      f = mk(BCST, 1'b0, 16'h0806, 16'd1, 48'h1, 32'h2, 32'hC0A8010A, 5);
      f[5] = 8'h54;
      run(f, "pre_bad");

      f = mk(BCST, 1'b0, 16'h0806, 16'd3, 48'h1, 32'h2, 32'hC0A8010A, 5);
      run(f, "oper3");

      f = mk(BCST, 1'b0, 16'h0806, 16'd1, 48'h3, 32'h4, 32'hC0A8010A, 5);
      f = f[0:31];
      g = mk(BMAC, 1'b0, 16'h0806, 16'd2, 48'h5, 32'h6, 32'hC0A8010C, 3);
      run2(f, g, "trunc_then_ok");

      f = mk(BCST, 1'b0, 16'h0806, 16'd1, 48'hA1, 32'hB1, 32'hC0A8010A, 0);
      g = mk(BMAC, 1'b1, 16'h0806, 16'd2, 48'hA2, 32'hB2, 32'hC0A8010C, 0);
      run2(f, g, "b2b");

      f = mk(48'h0011_2233_4456, 1'b0, 16'h0806, 16'd1, 48'h7, 32'h8, 32'hC0A8010A, 2);
      run(f, "mac_filt");

      f = mk(BCST, 1'b0, 16'h0806, 16'd1, 48'h9, 32'hA, 32'h01020304, 2);
      run(f, "ip_filt");

      for (int k = 0; k < 60; k++) begin
         logic [47:0] dst;
         logic [15:0] et;
         logic [15:0] op;
         logic [31:0] ti;
         bit          vl;
         int          j;
         j   = $urandom_range(0, 7);
         dst = (j < 4) ? BCST : (j < 7) ? BMAC : 48'h0011_2233_4456;
         vl  = ($urandom_range(0, 2) == 0);
         et  = ($urandom_range(0, 9) == 0) ? 16'h0800 : 16'h0806;
         op  = 16'($urandom_range(1, 2));
         if ($urandom_range(0, 9) == 0) op = 16'($urandom_range(3, 5));
         j   = $urandom_range(0, 3);
         ti  = lip[32*j +: 32];
         if ($urandom_range(0, 4) == 0) ti = $urandom;
         f = mk(dst, vl, et, op, {16'($urandom), 32'($urandom)}, $urandom, ti,
                $urandom_range(0, 20));
         if ($urandom_range(0, 14) == 0) begin
            j = $urandom_range(1, 7);
            f[j] = f[j] ^ 8'($urandom_range(1, 255));
         end
         if ($urandom_range(0, 14) == 0) begin
            j = vl ? 27 : 23;
            f[j] = 8'h02;
         end
         if ($urandom_range(0, 7) == 0) begin
            j = $urandom_range(2, f.size() - 1);
            f = f[0:j-1];
         end
         run(f, $sformatf("rnd%0d", k));
      end

      force dut0.r_err_cnt = 16'hFFFE;
      @(negedge clk);
      release dut0.r_err_cnt;
      m0.err = 16'hFFFE;
      f = mk(BCST, 1'b0, 16'h0806, 16'd3, 48'h1, 32'h2, 32'hC0A8010A, 1);
      run(f, "sat1");
      chk("sat1 ffff", 64'(err0), 64'hFFFF);
      f = mk(BCST, 1'b0, 16'h0806, 16'd1, 48'h1, 32'h2, 32'hC0A8010A, 1);
      f[3] = 8'h00;
      run(f, "sat2");
      chk("sat2 ffff", 64'(err0), 64'hFFFF);

      d0 = n_done0;
      f = mk(BCST, 1'b0, 16'h0806, 16'd1, 48'hDEAD, 32'hBEEF, 32'hC0A8010A, 10);
      for (int i = 0; i < 34; i++) begin
         @(posedge clk); #1;
         dv = 1'b1;
         rxd = f[i];
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      rxd = f[34];
      @(negedge clk); #1;
      chk_zero("midrst");
      chk("midrst err1", 64'(err1), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m0 = '0;
      m1 = '0;
      send(f);
      settle();
      chk("midrst nodone0", 64'(n_done0), 64'(d0));
      chk("midrst err0 after", 64'(err0), 64'd0);
      e_done1 = n_done1;
      e_done0 = d0;
      f = mk(BMAC, 1'b0, 16'h0806, 16'd2, 48'hCAFE, 32'hF00D, 32'hC0A8010C, 4);
      run(f, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
